pong_input_ctrl: RTL

Front-end controller for the game's push-button inputs. It synchronizes and debounces the raw button lines and turns press edges into queued event words. Firmware pops these events through a small Avalon-MM slave, which replaces the bare input PIO. A level-sensitive interrupt tells the Nios that events are pending, so firmware no longer polls raw, bouncy levels.

---
 rtl/pong_input_pkg.sv | 13 +
 rtl/pong_input_ctrl_debounce.sv | 46 ++++
 rtl/pong_input_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pong_input_pkg.sv
// Shared register-map constants for the push-button input controller.
package pong_input_pkg;

  localparam logic [1:0] ADDR_LEVEL  = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int EVT_VALID_BIT = 31;
  localparam int IRQ_EN_BIT    = 31;
  localparam int OVF_BIT       = 8;

endpackage

// File: rtl/pong_input_ctrl_debounce.sv
// Single-bit button conditioner: 2-flop synchronizer followed by a stability counter.
module pong_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample agreeing with the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/pong_input_ctrl.sv
// Debounced button front end: press edges are queued as event words and popped
// by firmware over an Avalon-MM slave, with a level interrupt while events wait.
module pong_input_ctrl
  import pong_input_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] r_mask;
  logic             r_irq_en;
  logic             r_irq;
  logic             r_overflow;
  logic [31:0]      r_readdata;
  logic [31:0]      w_rdata;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_nonempty;
  logic w_push_ok;
  logic w_drop;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_unused_wdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    pong_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (in_port[g]),
      .o_stable(w_stable[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stable_d <= '0;
    else          r_stable_d <= w_stable;
  end

  // The mask is applied at edge time, so already-queued events survive mask writes.
  assign w_ev        = w_stable & ~r_stable_d & r_mask;
  assign w_push      = |w_ev;
  assign w_nonempty  = (r_count != '0);
  assign w_full      = (r_count == CNT_FULL);
  assign w_pop       = read && (address == ADDR_EVENT) && w_nonempty;
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_wr_ctrl   = write && (address == ADDR_CTRL);
  assign w_wr_status = write && (address == ADDR_STATUS);

  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_ev;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a STATUS write wins, so no overflow is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_overflow <= 1'b0;
    else if (w_drop)      r_overflow <= 1'b1;
    else if (w_wr_status) r_overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask   <= '1;
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_mask   <= writedata[WIDTH-1:0];
      r_irq_en <= writedata[IRQ_EN_BIT];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_LEVEL: w_rdata[WIDTH-1:0] = w_stable;
      ADDR_EVENT: begin
        if (w_nonempty) begin
          w_rdata[EVT_VALID_BIT] = 1'b1;
          w_rdata[WIDTH-1:0]     = r_mem[r_rd_ptr];
        end
      end
      ADDR_CTRL: begin
        w_rdata[WIDTH-1:0]  = r_mask;
        w_rdata[IRQ_EN_BIT] = r_irq_en;
      end
      default: begin
        w_rdata[CNT_W-1:0] = r_count;
        w_rdata[OVF_BIT]   = r_overflow;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (read) r_readdata <= w_rdata;
      r_irq <= r_irq_en & w_nonempty;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
